// File: rtl/uart.sv
// uart: 8N1 serial transmitter; tx falls on the accepting edge and done strobes 10*CLKS_PER_BIT cycles later.
// No backpressure path: send rising edges seen while a frame is in flight are dropped, never queued.
module uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        send_q;
  logic        bit_end;

  assign bit_end = (timer == BIT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      send_q  <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      send_q <= send;
      done   <= 1'b0;
      if (state != IDLE) begin
        timer <= bit_end ? 16'd0 : timer + 16'd1;
      end
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          timer <= 16'd0;
          // Edge detect against the registered history so a held send cannot retrigger.
          if (send && !send_q) begin
            shreg   <= data;
            bit_idx <= 3'd0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart with CLKS_PER_BIT=4; inputs change and outputs are sampled on the falling clock edge.
module tb_uart;

  localparam int CPB = 4;

  logic       clock;
  logic       reset_n;
  logic       send;
  logic [7:0] data;
  logic       done;
  logic       tx;

  int checks = 0;
  int errors = 0;

  uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .send   (send),
    .data   (data),
    .done   (done),
    .tx     (tx)
  );

  initial begin
    clock = 1'b1;
    forever #10 clock = ~clock;
  end

  // Expected line level k cycles after the start edge: start bit, d0..d7, then stop/idle.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: tx=%b done=%b, expected tx=1 done=0", name, i, tx, done);
      end
    end
  endtask

  // Call at a falling edge with send already driven high; k=0 is the falling edge after the start edge.
  task automatic drive_frame(input string name, input logic [7:0] b, input int drop_k,
                             input int rise_k, input logic [7:0] rise_data, input int drop2_k);
    logic exp_done;
    for (int k = 0; k <= 10 * CPB; k++) begin
      @(negedge clock);
      exp_done = (k == 10 * CPB);
      checks++;
      if (tx !== exp_tx(b, k)) begin
        errors++;
        $display("FAIL %s tx k=%0d: got %b, expected %b", name, k, tx, exp_tx(b, k));
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done k=%0d: got %b, expected %b", name, k, done, exp_done);
      end
      if (k == 1) data = ~b;
      if (k == drop_k) send = 1'b0;
      if (k == rise_k) begin
        send = 1'b1;
        data = rise_data;
      end
      if (k == drop2_k) send = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    send    = 1'b0;
    data    = 8'h00;
    #1;
    checks++;
    if (tx !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b done=%b, expected tx=1 done=0", tx, done);
    end
    #49 reset_n = 1'b1;
    expect_idle("post_reset", 10);
  endtask

  task automatic test_short_pulse;
    data = 8'h40;
    #2 send = 1'b1;
    #5 send = 1'b0;
    expect_idle("short_pulse", 20);
  endtask

  task automatic test_basic;
    send = 1'b1;
    data = 8'h40;
    drive_frame("basic_40", 8'h40, 1, -1, 8'h00, -1);
    expect_idle("basic_after", 5);
  endtask

  task automatic test_ignore_mid;
    send = 1'b1;
    data = 8'h40;
    drive_frame("mid_send", 8'h40, 1, 12, 8'hFF, 16);
    expect_idle("mid_send_after", 8);
  endtask

  task automatic test_held_send;
    send = 1'b1;
    data = 8'h81;
    drive_frame("held_81", 8'h81, 1000, -1, 8'h00, -1);
    expect_idle("held_no_restart", 10);
    send = 1'b0;
    expect_idle("held_release", 2);
  endtask

  task automatic test_rise_on_done;
    send = 1'b1;
    data = 8'h5A;
    drive_frame("done_edge_5A", 8'h5A, 1, 39, 8'hC3, -1);
    expect_idle("done_edge_ignored", 10);
    send = 1'b0;
    expect_idle("done_edge_release", 1);
  endtask

  task automatic test_back_to_back;
    send = 1'b1;
    data = 8'hA5;
    drive_frame("b2b_first", 8'hA5, 1, 10 * CPB, 8'hA5, -1);
    drive_frame("b2b_second", 8'hA5, 1, -1, 8'h00, -1);
    expect_idle("b2b_after", 5);
  endtask

  task automatic test_reset_mid;
    send = 1'b1;
    data = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 1) send = 1'b0;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pre: tx=%b, expected 0 (data bit 1 of 0x3C)", tx);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: tx=%b done=%b, expected tx=1 done=0", tx, done);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    expect_idle("reset_mid_quiet", 45);
    send = 1'b1;
    data = 8'h3C;
    drive_frame("after_reset_3C", 8'h3C, 1, -1, 8'h00, -1);
    expect_idle("after_reset_idle", 3);
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_basic();
    test_ignore_mid();
    test_held_send();
    test_rise_on_done();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
